mem_arbiter: RTL

- Shares the single four-bank main memory between the instruction-cache FSM (I side) and the data-cache FSM (D side).
- Grants memory ownership to one requester for a whole burst (evict writebacks plus fill reads).
- Forwards the owner's accesses to memory and routes returned read data to the requester that issued the read.
- Sits between the two cache controllers and the memory; each controller sees a private memory port with an extra stall.

---
 rtl/mem_arbiter_pkg.sv | 34 +++
 rtl/mem_arbiter_tag_pipe.sv | 34 +++
 rtl/mem_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D memory arbiter: FSM states, requester sides and tag-pipe entries.
package mem_arbiter_pkg;

    localparam int MEM_LAT_DEFAULT = 2;
    localparam int ADDR_W          = 16;
    localparam int DATA_W          = 16;
    localparam int NUM_BANKS       = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_t;

    typedef struct packed {
        logic  valid;
        side_t side;
    } tag_t;

    function automatic side_t other_side(input side_t s);
        return (s == SIDE_I) ? SIDE_D : SIDE_I;
    endfunction

    function automatic arb_state_t grant_state(input side_t s);
        return (s == SIDE_D) ? GNT_D : GNT_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_tag_pipe.sv
// Fixed-depth shift register remembering which side issued each accepted memory read,
// so returned data can be steered once the memory latency has elapsed.
module arb_tag_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = MEM_LAT_DEFAULT
) (
    input  logic  clk,
    input  logic  clr,
    input  logic  push_valid,
    input  side_t push_side,
    output logic  out_valid,
    output side_t out_side
);

    tag_t pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{valid: push_valid, side: push_side};
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign out_valid = pipe[DEPTH-1].valid;
    assign out_side  = pipe[DEPTH-1].side;

endmodule

// File: rtl/mem_arbiter.sv
// Burst-granular arbiter sharing one main memory between the I-cache and D-cache controllers;
// forwards the owner's accesses and routes read data back to the side that issued each read.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 ic_req,
    input  logic [ADDR_W-1:0]    ic_addr,
    input  logic [DATA_W-1:0]    ic_data_in,
    input  logic                 ic_rd,
    input  logic                 ic_wr,
    output logic                 ic_gnt,
    output logic [DATA_W-1:0]    ic_data_out,
    output logic                 ic_dvalid,
    output logic                 ic_stall,
    output logic                 ic_err,

    input  logic                 dc_req,
    input  logic [ADDR_W-1:0]    dc_addr,
    input  logic [DATA_W-1:0]    dc_data_in,
    input  logic                 dc_rd,
    input  logic                 dc_wr,
    output logic                 dc_gnt,
    output logic [DATA_W-1:0]    dc_data_out,
    output logic                 dc_dvalid,
    output logic                 dc_stall,
    output logic                 dc_err,

    output logic [ADDR_W-1:0]    m_addr,
    output logic [DATA_W-1:0]    m_data_in,
    output logic                 m_rd,
    output logic                 m_wr,
    input  logic [DATA_W-1:0]    m_data_out,
    input  logic [NUM_BANKS-1:0] m_busy,
    input  logic                 m_stall,
    input  logic                 m_err
);

    // state | meaning
    // IDLE  | nobody owns memory; pick the next owner (round-robin on a tie)
    // GNT_I | I side owns memory for its burst
    // GNT_D | D side owns memory for its burst
    // DRAIN | MEM_LAT quiet cycles so in-flight reads return before a handoff

    localparam int                CNT_W      = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_t       state, state_next;
    side_t            last_owner, last_owner_next;
    logic [CNT_W-1:0] drain_cnt, drain_next;

    logic              own_valid;
    side_t             own_side;
    logic              own_req, own_rd, own_wr;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_din;
    logic              own_stall, own_err;

    logic              tag_valid;
    side_t             tag_side;

    // Bank conflicts reach the owner through m_stall; per-bank busy plays no part in arbitration.
    logic unused_busy;
    assign unused_busy = ^m_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= SIDE_I;
            drain_cnt  <= '0;
        end else begin
            state      <= state_next;
            last_owner <= last_owner_next;
            drain_cnt  <= drain_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_owner_next = last_owner;
        drain_next      = drain_cnt;
        case (state)
            IDLE: begin
                if (ic_req && dc_req) begin
                    state_next = grant_state(other_side(last_owner));
                end else if (ic_req) begin
                    state_next = GNT_I;
                end else if (dc_req) begin
                    state_next = GNT_D;
                end
            end
            GNT_I: begin
                if (!ic_req) begin
                    state_next      = DRAIN;
                    last_owner_next = SIDE_I;
                    drain_next      = DRAIN_LOAD;
                end
            end
            GNT_D: begin
                if (!dc_req) begin
                    state_next      = DRAIN;
                    last_owner_next = SIDE_D;
                    drain_next      = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    drain_next = drain_cnt - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        own_valid = (state == GNT_I) || (state == GNT_D);
        own_side  = (state == GNT_D) ? SIDE_D : SIDE_I;
        own_req   = (own_side == SIDE_D) ? dc_req     : ic_req;
        own_rd    = (own_side == SIDE_D) ? dc_rd      : ic_rd;
        own_wr    = (own_side == SIDE_D) ? dc_wr      : ic_wr;
        own_addr  = (own_side == SIDE_D) ? dc_addr    : ic_addr;
        own_din   = (own_side == SIDE_D) ? dc_data_in : ic_data_in;
    end

    // The release cycle (req already low) and rd+wr collisions never reach memory.
    always_comb begin
        m_addr    = '0;
        m_data_in = '0;
        m_rd      = 1'b0;
        m_wr      = 1'b0;
        own_stall = 1'b0;
        own_err   = 1'b0;
        if (own_valid) begin
            m_addr    = own_addr;
            m_data_in = own_din;
            if (!own_req) begin
                own_stall = own_rd | own_wr;
            end else if (own_rd && own_wr) begin
                own_stall = 1'b1;
                own_err   = 1'b1;
            end else begin
                m_rd      = own_rd;
                m_wr      = own_wr;
                own_stall = m_stall;
                own_err   = m_err;
            end
        end
        if (rst) begin
            m_addr    = '0;
            m_data_in = '0;
            m_rd      = 1'b0;
            m_wr      = 1'b0;
            own_stall = 1'b0;
            own_err   = 1'b0;
        end
    end

    always_comb begin
        ic_gnt   = (state == GNT_I);
        dc_gnt   = (state == GNT_D);
        ic_stall = ic_req | ic_rd | ic_wr;
        dc_stall = dc_req | dc_rd | dc_wr;
        ic_err   = 1'b0;
        dc_err   = 1'b0;
        if (state == GNT_I) begin
            ic_stall = own_stall;
            ic_err   = own_err;
        end
        if (state == GNT_D) begin
            dc_stall = own_stall;
            dc_err   = own_err;
        end
        if (rst) begin
            ic_gnt   = 1'b0;
            dc_gnt   = 1'b0;
            ic_stall = 1'b0;
            dc_stall = 1'b0;
            ic_err   = 1'b0;
            dc_err   = 1'b0;
        end
    end

    arb_tag_pipe #(
        .DEPTH (MEM_LAT)
    ) u_tag_pipe (
        .clk        (clk),
        .clr        (rst),
        .push_valid (m_rd & ~m_stall),
        .push_side  (own_side),
        .out_valid  (tag_valid),
        .out_side   (tag_side)
    );

    always_comb begin
        ic_dvalid   = ~rst & tag_valid & (tag_side == SIDE_I);
        dc_dvalid   = ~rst & tag_valid & (tag_side == SIDE_D);
        ic_data_out = ic_dvalid ? m_data_out : '0;
        dc_data_out = dc_dvalid ? m_data_out : '0;
    end

endmodule
